// File: rtl/rf_wr_arbiter.sv
//==============================================================================
// Module   : rf_wr_arbiter
// Brief    : Two-requester register-file write arbiter with alternating tie
//            priority, one-cycle registered write port and grant counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_wr_arbiter #(
  parameter int WIDTH    = 21,
  parameter int ADDR_W   = 3,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              wr_src,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
);

  typedef enum logic [0:0] {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } state_t;

  localparam logic [7:0] c_cnt_max = 8'hFF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_issue;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WIDTH-1:0]  w_sel_data;

  // Grants are blocked while the reset input is asserted, so nothing can
  // transfer during reset even though ready is combinational.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    if (rst && !hold) begin
      if (req0_valid && (!req1_valid || (r_state == PRI0))) begin
        w_gnt0 = 1'b1;
      end else if (req1_valid) begin
        w_gnt1 = 1'b1;
      end
    end
    if (w_gnt0) begin
      w_state_nxt = PRI1;
    end else if (w_gnt1) begin
      w_state_nxt = PRI0;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_xfer     = w_gnt0 | w_gnt1;
  assign w_sel_addr = w_gnt1 ? req1_addr : req0_addr;
  assign w_sel_data = w_gnt1 ? req1_data : req0_data;
  // A write to register 0 is accepted but swallowed when it is hardwired.
  assign w_issue    = w_xfer && !(ZERO_REG && (w_sel_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= PRI0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_src  <= 1'b0;
    end else begin
      wr_en <= w_issue;
      if (w_issue) begin
        wr_addr <= w_sel_addr;
        wr_data <= w_sel_data;
        wr_src  <= w_gnt1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (w_gnt0 && (gnt_cnt0 != c_cnt_max)) begin
        gnt_cnt0 <= gnt_cnt0 + 8'd1;
      end
      if (w_gnt1 && (gnt_cnt1 != c_cnt_max)) begin
        gnt_cnt1 <= gnt_cnt1 + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
//==============================================================================
// Module   : tb_rf_wr_arbiter
// Brief    : Randomised bench for rf_wr_arbiter (ZERO_REG=0 and =1 instances)
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rf_wr_arbiter;

  localparam int WIDTH  = 21;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst;
  logic              hold;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [WIDTH-1:0]  req0_data;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [WIDTH-1:0]  req1_data;

  logic              rdy0   [2];
  logic              rdy1   [2];
  logic              wen    [2];
  logic [ADDR_W-1:0] waddr  [2];
  logic [WIDTH-1:0]  wdata  [2];
  logic              wsrc   [2];
  logic [7:0]        cnt0   [2];
  logic [7:0]        cnt1   [2];

  int total = 0;
  int bad   = 0;

  // reference model state
  int                m_pri;
  bit                m_en   [2];
  logic [ADDR_W-1:0] m_addr [2];
  logic [WIDTH-1:0]  m_data [2];
  bit                m_src  [2];
  int                m_cnt0;
  int                m_cnt1;
  bit                last_g0;
  bit                last_g1;

  rf_wr_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[0]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[0]),
    .wr_en(wen[0]), .wr_addr(waddr[0]), .wr_data(wdata[0]), .wr_src(wsrc[0]),
    .gnt_cnt0(cnt0[0]), .gnt_cnt1(cnt1[0])
  );

  rf_wr_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rdy0[1]),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rdy1[1]),
    .wr_en(wen[1]), .wr_addr(waddr[1]), .wr_data(wdata[1]), .wr_src(wsrc[1]),
    .gnt_cnt0(cnt0[1]), .gnt_cnt1(cnt1[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pri   = 0;
    m_cnt0  = 0;
    m_cnt1  = 0;
    last_g0 = 1'b0;
    last_g1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_en[i]   = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
      m_src[i]  = 1'b0;
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wr_en%0d", i),    32'(wen[i]),   32'(m_en[i]));
      check($sformatf("wr_addr%0d", i),  32'(waddr[i]), 32'(m_addr[i]));
      check($sformatf("wr_data%0d", i),  32'(wdata[i]), 32'(m_data[i]));
      check($sformatf("wr_src%0d", i),   32'(wsrc[i]),  32'(m_src[i]));
      check($sformatf("gnt_cnt0_%0d", i), 32'(cnt0[i]), 32'(m_cnt0));
      check($sformatf("gnt_cnt1_%0d", i), 32'(cnt1[i]), 32'(m_cnt1));
    end
  endtask

  // One clock: inputs already applied at the falling edge.
  task automatic cycle();
    int                winner;
    bit                issue;
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
    #1;
    winner = -1;
    if (rst && !hold) begin
      if (req0_valid && req1_valid) winner = m_pri;
      else if (req0_valid)          winner = 0;
      else if (req1_valid)          winner = 1;
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("req0_ready%0d", i), 32'(rdy0[i]), 32'(winner == 0));
      check($sformatf("req1_ready%0d", i), 32'(rdy1[i]), 32'(winner == 1));
    end
    a = (winner == 1) ? req1_addr : req0_addr;
    d = (winner == 1) ? req1_data : req0_data;
    for (int i = 0; i < 2; i++) begin
      issue   = (winner >= 0) && !((i == 1) && (a == '0));
      m_en[i] = issue;
      if (issue) begin
        m_addr[i] = a;
        m_data[i] = d;
        m_src[i]  = (winner == 1);
      end
    end
    if (winner == 0) m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
    if (winner == 1) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
    if (winner >= 0) m_pri = 1 - winner;
    last_g0 = (winner == 0);
    last_g1 = (winner == 1);
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  // Reset applied from a falling edge; released two falling edges later.
  task automatic apply_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready0_%0d", i), 32'(rdy0[i]), 32'd0);
      check($sformatf("rst_ready1_%0d", i), 32'(rdy1[i]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    if (!(req0_valid && !last_g0)) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_addr  = ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom_range(0, 7));
      req0_data  = WIDTH'($urandom);
    end
    if (!(req1_valid && !last_g1)) begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_addr  = ($urandom_range(0, 3) == 0) ? '0 : ADDR_W'($urandom_range(0, 7));
      req1_data  = WIDTH'($urandom);
    end
    hold = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    hold = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    apply_reset();

    // single request
    req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 21'h1ABCD;
    cycle();
    check("single_cnt0", 32'(cnt0[0]), 32'd1);
    check("single_data", 32'(wdata[0]), 32'h1ABCD);
    req0_valid = 1'b0;
    cycle();

    // contention from reset
    apply_reset();
    req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 21'h00011;
    req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 21'h00022;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("contend_src", 32'(wsrc[0]), 32'(k % 2));
    end

    // hold with both valid
    hold = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    hold = 1'b0;
    cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cycle();

    // hardwired register 0
    req1_valid = 1'b1; req1_addr = 3'd0; req1_data = 21'h155555;
    cycle();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 21'h0BEEF;
    cycle();
    req0_valid = 1'b0;
    cycle();

    // counter saturation
    for (int k = 0; k < 300; k++) begin
      req0_valid = 1'b1;
      req0_addr  = ADDR_W'($urandom_range(1, 7));
      req0_data  = WIDTH'($urandom);
      cycle();
    end
    check("sat_cnt0", 32'(cnt0[0]), 32'd255);
    req0_valid = 1'b0;
    cycle();

    // random traffic with an asynchronous reset mid-stream
    for (int k = 0; k < 400; k++) begin
      rand_inputs();
      if (k == 200) begin
        req0_valid = 1'b1; req1_valid = 1'b1; hold = 1'b0;
        #2;
        apply_reset();
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter: WIDTH, 21, register data width.
REQ-002 Parameter: ADDR_W, 3, register address width (8 registers).
REQ-003 Parameter: ZERO_REG, 0, when 1 writes to address 0 are accepted but never issued.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: hold  input  1  register-file stall; no grants while high.
REQ-007 Port: req0_valid  input  1  requester 0 write request.
REQ-008 Port: req0_addr  input  ADDR_W  requester 0 target register.
REQ-009 Port: req0_data  input  WIDTH  requester 0 write data.
REQ-010 Port: req0_ready  output  1  requester 0 accepted this cycle.
REQ-011 Port: req1_valid / req1_addr / req1_data / req1_ready, same as requester 0 for requester 1.
REQ-012 Port: wr_en  output  1  register-file write enable (drives decoder enable).
REQ-013 Port: wr_addr  output  ADDR_W  register-file write address.
REQ-014 Port: wr_data  output  WIDTH  register-file write data.
REQ-015 Port: wr_src  output  1  requester index of the current wr_en cycle.
REQ-016 Port: gnt_cnt0 / gnt_cnt1  output  8 each  saturating accepted-transfer counters.

Function
REQ-017 Transfer on requester n SHALL occur in a cycle where reqn_valid and reqn_ready are both 1.
REQ-018 reqn_ready SHALL be combinational from valid, hold and state; at most one ready high per cycle.
REQ-019 hold=1 SHALL force both ready low; registered outputs still update per REQ-024.
REQ-020 Priority FSM states: PRI0 (requester 0 wins ties), PRI1 (requester 1 wins ties).
REQ-021 Only one valid -> that requester SHALL be granted regardless of state.
REQ-022 Both valid -> priority requester SHALL be granted; the other sees ready=0 and must hold valid/addr/data stable.
REQ-023 FSM transitions: grant to 0 -> PRI1; grant to 1 -> PRI0; no grant -> state unchanged.
REQ-024 Latency: a transfer in cycle N SHALL produce wr_en=1 with that addr/data/src in cycle N+1; cycles without a transfer SHALL produce wr_en=0.
REQ-025 wr_addr, wr_data, wr_src SHALL hold last issued values while wr_en=0.
REQ-026 ZERO_REG=1 and granted addr=0: transfer completes (ready=1, counter increments, FSM advances) but wr_en SHALL be 0 in cycle N+1.
REQ-027 gnt_cntn SHALL increment by 1 per transfer on requester n and saturate at 255.
REQ-028 Same-address requests from both requesters SHALL be serialised in grant order; later write lands one cycle later (last writer wins).
REQ-029 Back-to-back transfers SHALL sustain one write per cycle with no bubble.

Reset
REQ-030 rst=0 SHALL immediately (no clock) set FSM=PRI0, wr_en=0, wr_addr=0, wr_data=0, wr_src=0, gnt_cnt0=gnt_cnt1=0.
REQ-031 While rst=0 both ready SHALL be 0; a transfer in flight when reset asserts SHALL be discarded (no wr_en after release).
REQ-032 First rising edge after rst deasserts SHALL behave as normal cycle from PRI0.

Verification
REQ-033 Single request: req0 valid addr=3 data=0x1ABCD, req1 idle -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=0x1ABCD, wr_src=0; gnt_cnt0=1.
REQ-034 Contention: both valid continuously from reset, addr 1/2 -> grants alternate 0,1,0,1; wr_src sequence 0,1,0,1 with wr_en=1 every cycle from second cycle.
REQ-035 Hold: both valid, hold=1 for 3 cycles -> both ready 0, wr_en=0 for those cycles, FSM unchanged; on hold=0 priority requester granted first.
REQ-036 ZERO_REG=1: req1 addr=0 data=0x155555 -> req1_ready=1, gnt_cnt1 increments, next cycle wr_en=0; following req0 addr=0 granted (FSM advanced).
REQ-037 Saturation: 300 transfers on requester 0 -> gnt_cnt0=255, gnt_cnt1 unchanged.
REQ-038 Async reset mid-stream: rst pulled low between clock edges during continuous grants -> outputs reach REQ-030 values before next edge; no wr_en on first cycle after release unless a new transfer occurred.
